// File: rtl/control_pulses_pkg.sv
// rtl/control_pulses_pkg.sv - state, mux and ALU encodings plus per-state step lengths for control_pulses
package control_pulses_pkg;

  typedef enum logic [4:0] {
    ST_TC     = 5'd0,
    ST_TCF    = 5'd2,
    ST_CA     = 5'd3,
    ST_CS     = 5'd4,
    ST_AD     = 5'd5,
    ST_TS     = 5'd6,
    ST_MASK   = 5'd7,
    ST_XCH    = 5'd8,
    ST_NOOP   = 5'd9,
    ST_INCR   = 5'd10,
    ST_EXTEND = 5'd11,
    ST_LOAD   = 5'd12,
    ST_SU     = 5'd13
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5,
    ALU_NOT  = 3'd6,
    ALU_INC  = 3'd7
  } alu_op_t;

  localparam logic MADDR_Z = 1'b0;
  localparam logic MADDR_B = 1'b1;

  localparam logic MDATA_G   = 1'b0;
  localparam logic MDATA_ALU = 1'b1;

  localparam logic LP_ALU = 1'b0;
  localparam logic LP_G   = 1'b1;

  localparam logic G_MEM = 1'b0;
  localparam logic G_ALU = 1'b1;

  localparam logic B_G   = 1'b0;
  localparam logic B_ALU = 1'b1;

  localparam logic [1:0] Q_ALU  = 2'd0;
  localparam logic [1:0] Q_G    = 2'd1;
  localparam logic [1:0] Q_Z    = 2'd2;
  localparam logic [1:0] Q_ZERO = 2'd3;

  localparam logic [1:0] A_ALU  = 2'd0;
  localparam logic [1:0] A_G    = 2'd1;
  localparam logic [1:0] A_Q    = 2'd2;
  localparam logic [1:0] A_ZERO = 2'd3;

  localparam logic [1:0] X_A    = 2'd0;
  localparam logic [1:0] X_G    = 2'd1;
  localparam logic [1:0] X_Z    = 2'd2;
  localparam logic [1:0] X_ZERO = 2'd3;

  localparam logic [1:0] Z_ALU = 2'd0;
  localparam logic [1:0] Z_G   = 2'd1;
  localparam logic [1:0] Z_B   = 2'd2;
  localparam logic [1:0] Z_Q   = 2'd3;

  localparam logic [2:0] Y_A    = 3'd0;
  localparam logic [2:0] Y_G    = 3'd1;
  localparam logic [2:0] Y_B    = 3'd2;
  localparam logic [2:0] Y_Q    = 3'd3;
  localparam logic [2:0] Y_Z    = 3'd4;
  localparam logic [2:0] Y_L    = 3'd5;
  localparam logic [2:0] Y_ZERO = 3'd6;
  localparam logic [2:0] Y_ONE  = 3'd7;

  localparam logic [2:0] FETCH_STEPS = 3'd4;

  typedef struct packed {
    logic       mem_wr;
    logic       lp_wr;
    logic       g_wr;
    logic       q_wr;
    logic       b_wr;
    logic       a_wr;
    logic       y_wr;
    logic       x_wr;
    logic       z_wr;
    logic       maddr_mux;
    logic       mdata_mux;
    logic       lp_mux;
    logic       g_mux;
    logic       b_mux;
    logic [1:0] q_mux;
    logic [1:0] a_mux;
    logic [1:0] x_mux;
    logic [1:0] z_mux;
    alu_op_t    alu_op;
    logic [2:0] y_mux;
  } ctrl_t;

  // Execute-phase length only; the common fetch tail follows it.
  function automatic logic [2:0] exec_steps(input state_t s);
    case (s)
      ST_TC, ST_CA, ST_TS:                      return 3'd2;
      ST_TCF:                                   return 3'd1;
      ST_CS, ST_AD, ST_SU, ST_MASK, ST_XCH,
      ST_INCR:                                  return 3'd3;
      default:                                  return 3'd0;
    endcase
  endfunction

  // Unknown codes report step 0 as final so they fall straight back to LOAD.
  function automatic logic [2:0] last_step(input state_t s);
    case (s)
      ST_TC, ST_TCF, ST_CA, ST_CS, ST_AD, ST_SU, ST_TS, ST_MASK,
      ST_XCH, ST_INCR, ST_NOOP, ST_EXTEND:
        return exec_steps(s) + FETCH_STEPS - 3'd1;
      default:
        return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_pulses_dispatch.sv
// rtl/control_pulses_dispatch.sv - combinational LOAD decode of opcode/qc/extracode to the next state
module control_pulses_dispatch
  import control_pulses_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] qc,
  input  logic       extracode,
  output state_t     next_state
);

  always_comb begin
    next_state = ST_NOOP;
    case (opcode)
      3'd0: next_state = ST_TC;
      3'd1: next_state = ST_TCF;
      3'd2: next_state = ST_INCR;
      3'd3: next_state = ST_CA;
      3'd4: next_state = ST_CS;
      3'd5: begin
        case (qc)
          2'd0: next_state = ST_NOOP;
          2'd1: next_state = ST_EXTEND;
          2'd2: next_state = ST_TS;
          default: next_state = ST_XCH;
        endcase
      end
      3'd6: next_state = extracode ? ST_SU : ST_AD;
      default: next_state = ST_MASK;
    endcase
  end

endmodule

// File: rtl/control_pulses.sv
// rtl/control_pulses.sv - AGC-style microsequencer driving register strobes, mux selects and ALU op
// Optional debug ports dbg_step/dbg_last are built when PULSES_DEBUG_EN is defined.
module control_pulses
  import control_pulses_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [1:0] qc,
  input  logic       extracode,
  output logic       ext_flag,
  output logic       mem_wr,
  output logic       lp_wr,
  output logic       g_wr,
  output logic       q_wr,
  output logic       b_wr,
  output logic       a_wr,
  output logic       y_wr,
  output logic       x_wr,
  output logic       z_wr,
  output logic       maddr_mux,
  output logic       mdata_mux,
  output logic       lp_mux,
  output logic       g_mux,
  output logic       b_mux,
  output logic [1:0] q_mux,
  output logic [1:0] a_mux,
  output logic [1:0] x_mux,
  output logic [1:0] z_mux,
  output logic [2:0] alu_op,
`ifdef PULSES_DEBUG_EN
  output logic [2:0] dbg_step,
  output logic       dbg_last,
`endif
  output logic [2:0] y_mux
);

  state_t     state;
  state_t     dispatch_state;
  logic [2:0] step;
  logic [2:0] exec_n;
  logic [2:0] fetch_idx;
  logic       is_last;
  ctrl_t      c;

  control_pulses_dispatch u_dispatch (
    .opcode     (opcode),
    .qc         (qc),
    .extracode  (extracode),
    .next_state (dispatch_state)
  );

  assign is_last = (state != ST_LOAD) && (step == last_step(state));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOAD;
      step     <= 3'd0;
      ext_flag <= 1'b0;
    end else if (state == ST_LOAD) begin
      state <= dispatch_state;
      step  <= 3'd0;
      if (dispatch_state != ST_EXTEND) ext_flag <= 1'b0;
    end else if (is_last) begin
      state <= ST_LOAD;
      step  <= 3'd0;
      if (state == ST_EXTEND) ext_flag <= 1'b1;
    end else begin
      step <= step + 3'd1;
    end
  end

  assign exec_n    = exec_steps(state);
  assign fetch_idx = step - exec_n;

  always_comb begin
    c = '0;
    if (state != ST_LOAD && step < exec_n) begin
      case (state)
        ST_TC: begin
          if (step == 3'd0) begin c.q_wr = 1'b1; c.q_mux = Q_Z; end
          else              begin c.z_wr = 1'b1; c.z_mux = Z_B; end
        end
        ST_TCF: begin
          c.z_wr = 1'b1; c.z_mux = Z_B;
        end
        ST_CA: begin
          if (step == 3'd0) begin c.g_wr = 1'b1; c.maddr_mux = MADDR_B; c.g_mux = G_MEM; end
          else              begin c.a_wr = 1'b1; c.a_mux = A_G; end
        end
        ST_CS: begin
          case (step)
            3'd0:    begin c.g_wr = 1'b1; c.maddr_mux = MADDR_B; c.g_mux = G_MEM; end
            3'd1:    begin c.x_wr = 1'b1; c.x_mux = X_G; end
            default: begin c.a_wr = 1'b1; c.a_mux = A_ALU; c.alu_op = ALU_NOT; end
          endcase
        end
        ST_AD, ST_SU, ST_MASK: begin
          case (step)
            3'd0: begin c.g_wr = 1'b1; c.maddr_mux = MADDR_B; c.g_mux = G_MEM; end
            3'd1: begin
              c.x_wr = 1'b1; c.x_mux = X_A;
              c.y_wr = 1'b1; c.y_mux = Y_G;
            end
            default: begin
              c.a_wr  = 1'b1;
              c.a_mux = A_ALU;
              c.alu_op = (state == ST_AD) ? ALU_ADD : (state == ST_SU) ? ALU_SUB : ALU_AND;
            end
          endcase
        end
        ST_TS: begin
          if (step == 3'd0) begin c.x_wr = 1'b1; c.x_mux = X_A; end
          else begin
            c.mem_wr = 1'b1; c.maddr_mux = MADDR_B; c.mdata_mux = MDATA_ALU; c.alu_op = ALU_PASS;
          end
        end
        ST_XCH: begin
          case (step)
            3'd0: begin c.g_wr = 1'b1; c.maddr_mux = MADDR_B; c.g_mux = G_MEM; end
            3'd1: begin c.x_wr = 1'b1; c.x_mux = X_A; end
            // G already holds the old memory word, so A can take it while X goes out.
            default: begin
              c.mem_wr = 1'b1; c.maddr_mux = MADDR_B; c.mdata_mux = MDATA_ALU; c.alu_op = ALU_PASS;
              c.a_wr   = 1'b1; c.a_mux = A_G;
            end
          endcase
        end
        ST_INCR: begin
          case (step)
            3'd0:    begin c.g_wr = 1'b1; c.maddr_mux = MADDR_B; c.g_mux = G_MEM; end
            3'd1:    begin c.x_wr = 1'b1; c.x_mux = X_G; end
            default: begin
              c.mem_wr = 1'b1; c.maddr_mux = MADDR_B; c.mdata_mux = MDATA_ALU; c.alu_op = ALU_INC;
            end
          endcase
        end
        default: c = '0;
      endcase
    end else if (state != ST_LOAD && step <= last_step(state)) begin
      case (fetch_idx[1:0])
        2'd0:    begin c.g_wr = 1'b1; c.maddr_mux = MADDR_Z; c.g_mux = G_MEM; end
        2'd1:    begin c.x_wr = 1'b1; c.x_mux = X_Z; end
        2'd2:    begin c.z_wr = 1'b1; c.z_mux = Z_ALU; c.alu_op = ALU_INC; end
        default: begin c.b_wr = 1'b1; c.b_mux = B_G; end
      endcase
    end
  end

  assign mem_wr    = c.mem_wr;
  assign lp_wr     = c.lp_wr;
  assign g_wr      = c.g_wr;
  assign q_wr      = c.q_wr;
  assign b_wr      = c.b_wr;
  assign a_wr      = c.a_wr;
  assign y_wr      = c.y_wr;
  assign x_wr      = c.x_wr;
  assign z_wr      = c.z_wr;
  assign maddr_mux = c.maddr_mux;
  assign mdata_mux = c.mdata_mux;
  assign lp_mux    = c.lp_mux;
  assign g_mux     = c.g_mux;
  assign b_mux     = c.b_mux;
  assign q_mux     = c.q_mux;
  assign a_mux     = c.a_mux;
  assign x_mux     = c.x_mux;
  assign z_mux     = c.z_mux;
  assign alu_op    = c.alu_op;
  assign y_mux     = c.y_mux;

`ifdef PULSES_DEBUG_EN
  assign dbg_step = step;
  assign dbg_last = is_last;
`endif

endmodule

// File: tb/tb_control_pulses.sv
// tb/tb_control_pulses.sv - directed self-checking bench for control_pulses
module tb_control_pulses;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic [1:0] qc;
  logic       extracode;
  logic       ext_flag;
  logic       mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr;
  logic       maddr_mux, mdata_mux, lp_mux, g_mux, b_mux;
  logic [1:0] q_mux, a_mux, x_mux, z_mux;
  logic [2:0] alu_op, y_mux;
`ifdef PULSES_DEBUG_EN
  logic [2:0] dbg_step;
  logic       dbg_last;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [27:0] all_ctl;
  assign all_ctl = {mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr,
                    maddr_mux, mdata_mux, lp_mux, g_mux, b_mux,
                    q_mux, a_mux, x_mux, z_mux, alu_op, y_mux};

  control_pulses dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .qc        (qc),
    .extracode (extracode),
    .ext_flag  (ext_flag),
    .mem_wr    (mem_wr),
    .lp_wr     (lp_wr),
    .g_wr      (g_wr),
    .q_wr      (q_wr),
    .b_wr      (b_wr),
    .a_wr      (a_wr),
    .y_wr      (y_wr),
    .x_wr      (x_wr),
    .z_wr      (z_wr),
    .maddr_mux (maddr_mux),
    .mdata_mux (mdata_mux),
    .lp_mux    (lp_mux),
    .g_mux     (g_mux),
    .b_mux     (b_mux),
    .q_mux     (q_mux),
    .a_mux     (a_mux),
    .x_mux     (x_mux),
    .z_mux     (z_mux),
    .alu_op    (alu_op),
`ifdef PULSES_DEBUG_EN
    .dbg_step  (dbg_step),
    .dbg_last  (dbg_last),
`endif
    .y_mux     (y_mux)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 3'd0; qc = 2'd0; extracode = 1'b0;
    tick();
    rst = 1'b0;
    check("reset_state", 32'(dut.state), 32'd12);
    check("reset_step", 32'(dut.step), 32'd0);
    check("reset_ctl", 32'(all_ctl), 32'd0);
    check("reset_ext", 32'(ext_flag), 32'd0);

    // MASK: 3 exec + 4 fetch
    opcode = 3'd7;
    check("load_ctl_zero", 32'(all_ctl), 32'd0);
    tick();
    check("mask_state", 32'(dut.state), 32'd7);
    check("mask_s0_g_wr", 32'(g_wr), 32'd1);
    check("mask_s0_maddr", 32'(maddr_mux), 32'd1);
    tick();
    check("mask_s1_xy", 32'({x_wr, x_mux, y_wr, y_mux}), 32'({1'b1, 2'd0, 1'b1, 3'd1}));
    tick();
    check("mask_s2_alu", 32'(alu_op), 32'd2);
    check("mask_s2_a_wr", 32'(a_wr), 32'd1);
    tick();
    check("mask_f0", 32'({g_wr, maddr_mux, g_mux}), 32'({1'b1, 1'b0, 1'b0}));
    tick();
    check("mask_f1", 32'({x_wr, x_mux}), 32'({1'b1, 2'd2}));
    tick();
    check("mask_f2", 32'({z_wr, z_mux, alu_op}), 32'({1'b1, 2'd0, 3'd7}));
    tick();
    check("mask_f3", 32'({b_wr, b_mux, g_wr}), 32'({1'b1, 1'b0, 1'b0}));
    tick();
    check("mask_back_load", 32'(dut.state), 32'd12);

    // EXTEND
    opcode = 3'd5; qc = 2'd1;
    tick();
    check("ext_state", 32'(dut.state), 32'd11);
    check("ext_s0_fetch", 32'(g_wr), 32'd1);
    tick(); tick(); tick();
    check("ext_flag_before_end", 32'(ext_flag), 32'd0);
    tick();
    check("ext_back_load", 32'(dut.state), 32'd12);
    check("ext_flag_set", 32'(ext_flag), 32'd1);

    // SU via fed-back ext_flag
    opcode = 3'd6; extracode = ext_flag;
    tick();
    extracode = 1'b0;
    check("su_state", 32'(dut.state), 32'd13);
    check("su_ext_clear", 32'(ext_flag), 32'd0);
    tick(); tick();
    check("su_s2_alu", 32'(alu_op), 32'd1);
    check("su_s2_a_wr", 32'(a_wr), 32'd1);
    tick(); tick(); tick(); tick(); tick();
    check("su_back_load", 32'(dut.state), 32'd12);

    // TC
    opcode = 3'd0;
    tick();
    check("tc_state", 32'(dut.state), 32'd0);
    check("tc_s0", 32'({q_wr, q_mux, z_wr}), 32'({1'b1, 2'd2, 1'b0}));
    tick();
    check("tc_s1", 32'({z_wr, z_mux, q_wr}), 32'({1'b1, 2'd2, 1'b0}));
    tick(); tick(); tick(); tick();
    check("tc_last_step", 32'(dut.state), 32'd0);
    tick();
    check("tc_back_load", 32'(dut.state), 32'd12);

    // XCH: store and A<-G together
    opcode = 3'd5; qc = 2'd3;
    tick();
    check("xch_state", 32'(dut.state), 32'd8);
    tick(); tick();
    check("xch_s2", 32'({mem_wr, maddr_mux, mdata_mux, alu_op, a_wr, a_mux}),
          32'({1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 2'd1}));
    tick(); tick(); tick(); tick(); tick();
    check("xch_back_load", 32'(dut.state), 32'd12);

    // Reset during MASK step 3
    opcode = 3'd7; qc = 2'd0;
    tick(); tick(); tick(); tick();
    check("mask_mid_step", 32'(dut.step), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 32'(dut.state), 32'd12);
    check("abort_step", 32'(dut.step), 32'd0);
    check("abort_ctl", 32'(all_ctl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_pulses.md
Name: control_pulses

Overview:
- Microsequencer for the ToTheMoon AGC-style CPU.
- Holds a 5-bit instruction state and a 3-bit step counter.
- In LOAD it dispatches on opcode/qc/extracode, then sequences one execute phase followed by a common 4-step fetch.
- Drives register write strobes, datapath mux selects and ALU op as a combinational function of (state, step).

Parameters:
- none (all encodings are fixed package constants)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  3  instruction opcode field (from B)
- qc  in  2  quarter-code field
- extracode  in  1  1 = current instruction is extended (fed back from ext_flag)
- ext_flag  out  1  registered; 1 after EXTEND until the next dispatch
- mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr  out  1 each  write strobes for memory and registers
- maddr_mux  out  1  0=Z, 1=B
- mdata_mux  out  1  0=G, 1=ALU
- lp_mux  out  1  0=ALU, 1=G
- g_mux  out  1  0=memory, 1=ALU
- b_mux  out  1  0=G, 1=ALU
- q_mux  out  2  0=ALU, 1=G, 2=Z, 3=zero
- a_mux  out  2  0=ALU, 1=G, 2=Q, 3=zero
- x_mux  out  2  0=A, 1=G, 2=Z, 3=zero
- z_mux  out  2  0=ALU, 1=G, 2=B, 3=Q
- alu_op  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=PASS X, 6=NOT X, 7=INC X
- y_mux  out  3  0=A, 1=G, 2=B, 3=Q, 4=Z, 5=L, 6=const0, 7=const1

Behaviour:
- Register named state (5b), encodings: TC=0, TCF=2, CA=3, CS=4, AD=5, TS=6, MASK=7, XCH=8, NOOP=9, INCR=10, EXTEND=11, LOAD=12, SU=13. Codes 1, 14–31 are unused.
- Reset: state=LOAD, step=0, ext_flag=0.
- LOAD lasts exactly 1 cycle. The next state is decoded from opcode/qc/extracode:
  - op0→TC
  - op1→TCF
  - op2→INCR
  - op3→CA
  - op4→CS
  - op5: qc0→NOOP, qc1→EXTEND, qc2→TS, qc3→XCH
  - op6→AD, or SU if extracode=1
  - op7→MASK
  - extracode has no other effect.
- Dispatch to any state except EXTEND clears ext_flag. EXTEND sets ext_flag on its final step.
- Execute state length = exec steps + 4 fetch steps: TC 6, TCF 5, CA 6, CS 7, AD 7, SU 7, TS 6, MASK 7, XCH 7, INCR 7, NOOP 4, EXTEND 4.
- On the final step, state←LOAD and step←0; otherwise step increments.
- Exec steps (listed strobes asserted; unlisted outputs are 0):
  - TC: Q←Z (q_mux=2); Z←B (z_mux=2)
  - TCF: Z←B
  - CA: G←mem[B] (maddr=1, g_mux=0); A←G (a_mux=1)
  - CS: G←mem[B]; X←G; A←NOT X
  - AD/SU/MASK: G←mem[B]; X←A and Y←G; A←X op Y (ADD/SUB/AND)
  - TS: X←A; mem[B]←PASS X (mem_wr, mdata=1)
  - XCH: G←mem[B]; X←A; mem[B]←PASS X and A←G in the same step
  - INCR: G←mem[B]; X←G; mem[B]←INC X
- Fetch tail (4 steps): G←mem[Z]; X←Z; Z←INC X; B←G.
- All strobes and selects are 0 in LOAD and during reset.
- Outputs are combinational from the registers; there are no extra latency stages.
- rst mid-instruction aborts to LOAD on the next edge.
- Mux/ALU fields are don't-care when their strobe is low; drive them to 0.
- lp_wr is never asserted by the current instruction set; it is reserved.

Optional Feature:
- Macro PULSES_DEBUG_EN.
- When defined, adds output dbg_step [2:0] mirroring the step counter, plus output dbg_last (1 on the final step of any execute state).
- When undefined, neither port exists; behaviour is otherwise identical.

Decomposition:
- control_pulses_pkg holds:
  - state encodings
  - all mux and alu_op encodings
  - the per-state length table
- One sub-module, control_pulses_dispatch: combinational LOAD decode of opcode/qc/extracode to the next state.

Test Plan:
- rst=1 one edge, then rst=0 → state=12, all strobes 0, ext_flag=0.
- From LOAD with opcode=7, extracode=0, one edge → state=7. Seven further edges → state=12. Step 2 shows alu_op=2, a_wr=1.
- From LOAD with opcode=5, qc=1 → state=11. Four edges later state=12 and ext_flag=1.
- With ext_flag=1 as extracode and opcode=6, dispatch → state=13 and ext_flag=0. Exec step 2 has alu_op=1.
- opcode=0 → state=0; step0 q_wr=1, q_mux=2; step1 z_wr=1, z_mux=2; back to 12 after 6 edges.
- Assert rst during MASK step 3 → next edge state=12, step=0, all outputs 0.
